gate_stim_checker: RTL and testbench

Self-checking stimulus stage for the two-input (or N-input) logic-gate blocks. Upstream, it drives every input combination onto the gate under test and holds each one for a fixed number of cycles. Downstream, it samples the gate's combinational output, compares it against the expected value for the selected gate function, and reports a mismatch count plus a pass/fail verdict. It lets a gate be exercised exhaustively in synthesizable form, without a behavioural bench.

---
 rtl/gate_stim_checker_if.sv | 24 ++
 rtl/gate_stim_checker.sv | 67 ++++++
 tb/tb_gate_stim_checker.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gate_stim_checker_if.sv
// gate_stim_checker_if: stimulus/check bundle between checker and gate under test
interface gate_stim_checker_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  logic             start;
  logic [1:0]       gate_op;
  logic [N_IN-1:0]  stim;
  logic             dut_out;
  logic             busy;
  logic [CNT_W-1:0] vec_idx;
  logic             mismatch;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  modport master (
    input  start, gate_op, dut_out,
    output stim, busy, vec_idx, mismatch, done, pass, err_count
  );
  modport slave (
    output start, gate_op, dut_out,
    input  stim, busy, vec_idx, mismatch, done, pass, err_count
  );
endinterface

// File: rtl/gate_stim_checker.sv
// gate_stim_checker: exhaustive gate stimulus with per-vector output check and verdict
module gate_stim_checker #(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input logic clk,
  input logic rst_n,
  gate_stim_checker_if.master bus
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;
  state_t           state, state_nx;
  logic [HW-1:0]    hold;
  logic [1:0]       op;
  logic             expected, check, last, miss;
  logic [CNT_W-1:0] err_nx;
  assign expected = op[1] ? (op[0] ? ~&bus.stim : ^bus.stim) : (op[0] ? |bus.stim : &bus.stim);
  assign check    = state == DRIVE && hold == '0;
  assign last     = &bus.stim;
  assign miss     = check && bus.dut_out != expected;
  assign err_nx   = miss && !(&bus.err_count) ? bus.err_count + 1'b1 : bus.err_count;
  assign bus.vec_idx = CNT_W'(bus.stim);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && bus.start) ? DRIVE :
               (check && last)              ? FINISH :
               (state == FINISH)            ? IDLE : state;
  end
  // the verdict folds in the last vector's compare, so it uses err_nx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stim      <= '0;
      bus.busy      <= 1'b0;
      bus.mismatch  <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= '0;
      hold          <= '0;
      op            <= '0;
    end else begin
      bus.mismatch <= miss;
      bus.done     <= check && last;
      if (state == IDLE && bus.start) begin
        op            <= bus.gate_op;
        bus.err_count <= '0;
        bus.pass      <= 1'b0;
        bus.stim      <= '0;
        hold          <= HW'(HOLD_CYCLES - 1);
        bus.busy      <= 1'b1;
      end else if (check) begin
        bus.err_count <= err_nx;
        if (last) begin
          bus.busy <= 1'b0;
          bus.pass <= err_nx == '0;
        end else begin
          bus.stim <= bus.stim + 1'b1;
          hold     <= HW'(HOLD_CYCLES - 1);
        end
      end else if (state == DRIVE) hold <= hold - 1'b1;
      else if (state == FINISH) bus.stim <= '0;
    end
  end
endmodule

// File: tb/tb_gate_stim_checker.sv
// tb_gate_stim_checker: directed runs with a scoreboard of expected mismatch/done events
module tb_gate_stim_checker;
  logic clk = 0, rst_n = 0, dut_mode = 0;
  int cyc = 0, n_assert = 0, n_fail = 0, k = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  gate_stim_checker_if #(.N_IN(2), .CNT_W(8)) b0();
  gate_stim_checker_if #(.N_IN(3), .CNT_W(2)) b1();
  assign b0.dut_out = dut_mode ? 1'b0 : &b0.stim;
  assign b1.dut_out = ~&b1.stim;
  gate_stim_checker u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  gate_stim_checker #(.N_IN(3), .HOLD_CYCLES(1), .CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  typedef struct {int cyc; int err;} ev_t;
  typedef struct {int cyc; logic pass; int err;} dn_t;
  ev_t mq0[$], mq1[$];
  dn_t dq0[$], dq1[$];
  logic em0, ed0, em1, ed1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  function automatic logic gexp(input logic [1:0] op, input int v, input int n);
    logic [7:0] s;
    logic a, o, x;
    s = v[7:0]; a = 1; o = 0; x = 0;
    for (int i = 0; i < n; i++) begin a &= s[i]; o |= s[i]; x ^= s[i]; end
    return op == 0 ? a : op == 1 ? o : op == 2 ? x : ~a;
  endfunction
  always @(negedge clk) begin
    em0 = mq0.size() > 0 && mq0[0].cyc == cyc;
    ed0 = dq0.size() > 0 && dq0[0].cyc == cyc;
    if (b0.mismatch || em0) begin
      chk("mis0", b0.mismatch, em0);
      if (em0) begin chk("mis0_err", b0.err_count, mq0[0].err); void'(mq0.pop_front()); end
    end
    if (b0.done || ed0) begin
      chk("done0", b0.done, ed0);
      if (ed0) begin
        chk("pass0", b0.pass, dq0[0].pass);
        chk("err0", b0.err_count, dq0[0].err);
        chk("fin_stim0", b0.stim, 3);
        chk("fin_busy0", b0.busy, 0);
        void'(dq0.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    em1 = mq1.size() > 0 && mq1[0].cyc == cyc;
    ed1 = dq1.size() > 0 && dq1[0].cyc == cyc;
    if (b1.mismatch || em1) begin
      chk("mis1", b1.mismatch, em1);
      if (em1) begin chk("mis1_err", b1.err_count, mq1[0].err); void'(mq1.pop_front()); end
    end
    if (b1.done || ed1) begin
      chk("done1", b1.done, ed1);
      if (ed1) begin
        chk("pass1", b1.pass, dq1[0].pass);
        chk("err1", b1.err_count, dq1[0].err);
        chk("fin_stim1", b1.stim, 7);
        void'(dq1.pop_front());
      end
    end
  end
  task automatic launch0(input logic [1:0] op, input logic mode, output int ks);
    int cnt;
    logic d;
    @(negedge clk);
    dut_mode = mode; b0.gate_op = op; b0.start = 1; ks = cyc + 1; cnt = 0;
    for (int v = 0; v < 4; v++) begin
      d = mode ? 1'b0 : (v == 3);
      if (d != gexp(op, v, 2)) begin cnt++; mq0.push_back(ev_t'{ks + (v + 1) * 10, cnt}); end
    end
    dq0.push_back(dn_t'{ks + 40, cnt == 0, cnt});
    @(negedge clk);
    b0.start = 0;
  endtask
  task automatic wait0();
    int t = 0;
    while (dq0.size() > 0 && t < 200) begin @(negedge clk); #1; t++; end
    chk("timeout0", dq0.size(), 0);
    chk("mis0_left", mq0.size(), 0);
  endtask
  task automatic at0(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_stim"}, b0.stim, 0);
    chk({tag, "_idx"}, b0.vec_idx, 0);
    chk({tag, "_busy"}, b0.busy, 0);
    chk({tag, "_mis"}, b0.mismatch, 0);
    chk({tag, "_done"}, b0.done, 0);
    chk({tag, "_pass"}, b0.pass, 0);
    chk({tag, "_err"}, b0.err_count, 0);
  endtask
  initial begin
    b0.start = 0; b0.gate_op = 0; b1.start = 0; b1.gate_op = 0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1;
    launch0(2'b00, 0, k);
    at0(k);      chk("t1_stim_a", b0.stim, 0); chk("t1_busy", b0.busy, 1);
    at0(k + 9);  chk("t1_stim_b", b0.stim, 0);
    at0(k + 10); chk("t1_stim_c", b0.stim, 1); chk("t1_idx", b0.vec_idx, 1);
    at0(k + 30); chk("t1_stim_d", b0.stim, 3);
    wait0();
    b0.start = 1;
    @(negedge clk);
    b0.start = 0;
    chk("fin_ign_busy", b0.busy, 0);
    chk("fin_ign_stim", b0.stim, 0);
    chk("hold_pass", b0.pass, 1);
    launch0(2'b00, 1, k);
    wait0();
    launch0(2'b11, 0, k);
    wait0();
    launch0(2'b00, 0, k);
    at0(k + 14); b0.start = 1;
    @(negedge clk); b0.start = 0;
    at0(k + 20); chk("t4_stim", b0.stim, 2); chk("t4_busy", b0.busy, 1);
    wait0();
    launch0(2'b11, 0, k);
    at0(k + 25); chk("t5_stim", b0.stim, 2); chk("t5_err", b0.err_count, 2);
    #2 rst_n = 0;
    #1 chk_zero("midrst");
    mq0.delete(); dq0.delete();
    @(negedge clk); rst_n = 1;
    launch0(2'b00, 0, k);
    at0(k); chk("t5b_stim", b0.stim, 0); chk("t5b_err", b0.err_count, 0); chk("t5b_busy", b0.busy, 1);
    wait0();
    @(negedge clk);
    b1.gate_op = 0; b1.start = 1; k = cyc + 1;
    for (int v = 0; v < 8; v++) mq1.push_back(ev_t'{k + v + 1, v + 1 > 3 ? 3 : v + 1});
    dq1.push_back(dn_t'{k + 8, 1'b0, 3});
    @(negedge clk); b1.start = 0;
    chk("t6_stim_a", b1.stim, 0);
    @(negedge clk); chk("t6_stim_b", b1.stim, 1);
    for (int t = 0; t < 50 && dq1.size() > 0; t++) begin @(negedge clk); #1; end
    chk("timeout1", dq1.size(), 0);
    chk("mis1_left", mq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
